// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Purpose  : Fetch-to-decode instruction FIFO with branch flush and RV64I
//            field/immediate extraction for the head entry.
// Revision : 1.0
// ============================================================================
module if_id_queue #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [63:0]              out_imm,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH) + 1;

  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_REG32  = 7'b0111011;

  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_CW-1:0]    r_count;

  logic               w_push;
  logic               w_pop;
  logic [PC_W-1:0]    w_head_pc;
  logic [INSTR_W-1:0] w_head_instr;
  logic [6:0]         w_opcode;
  logic [63:0]        w_imm;
  logic               w_known;

  // in_ready looks only at the registered count: no pass-through when full.
  assign in_ready  = rst_n && (r_count != c_FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through the out_valid gate.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_instr_mem[r_wr_ptr] <= in_instr;
    end
  end

  assign w_head_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign w_head_instr = out_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign w_opcode     = w_head_instr[6:0];

  always_comb begin
    w_imm   = '0;
    w_known = 1'b0;
    case (w_opcode)
      c_OP_LOAD, c_OP_IMM, c_OP_IMM32, c_OP_JALR: begin
        w_known = 1'b1;
        w_imm   = {{52{w_head_instr[31]}}, w_head_instr[31:20]};
      end
      c_OP_STORE: begin
        w_known = 1'b1;
        w_imm   = {{52{w_head_instr[31]}}, w_head_instr[31:25], w_head_instr[11:7]};
      end
      c_OP_BRANCH: begin
        w_known = 1'b1;
        w_imm   = {{51{w_head_instr[31]}}, w_head_instr[31], w_head_instr[7],
                   w_head_instr[30:25], w_head_instr[11:8], 1'b0};
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_known = 1'b1;
        w_imm   = {{32{w_head_instr[31]}}, w_head_instr[31:12], 12'b0};
      end
      c_OP_JAL: begin
        w_known = 1'b1;
        w_imm   = {{43{w_head_instr[31]}}, w_head_instr[31], w_head_instr[19:12],
                   w_head_instr[20], w_head_instr[30:21], 1'b0};
      end
      c_OP_REG, c_OP_REG32: begin
        w_known = 1'b1;
      end
      default: begin
        w_known = 1'b0;
      end
    endcase
  end

  // Every listed opcode ends in 2'b11, so a full 7-bit match covers that check.
  assign out_pc      = w_head_pc;
  assign out_instr   = w_head_instr;
  assign out_opcode  = w_opcode;
  assign out_rd      = w_head_instr[11:7];
  assign out_rs1     = w_head_instr[19:15];
  assign out_rs2     = w_head_instr[24:20];
  assign out_funct3  = w_head_instr[14:12];
  assign out_funct7  = w_head_instr[31:25];
  assign out_imm     = w_imm;
  assign out_illegal = out_valid && !w_known;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// Self-checking bench for if_id_queue: scoreboard of {pc, instr} in FIFO order
// plus constant decode expectations for known encodings.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int PC_W  = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [PC_W-1:0]  in_pc = '0;
  logic [31:0]      in_instr = '0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [31:0]      out_instr;
  logic [6:0]       out_opcode;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [63:0]      out_imm;
  logic             out_illegal;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  if_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  // Applies one cycle of stimulus and advances the reference queue to match.
  task automatic drive(input logic v, input logic [PC_W-1:0] pc,
                       input logic [31:0] ins, input logic rdy, input logic fl);
    bit push_ok, pop_ok;
    entry_t e;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
    push_ok = rst_n && v && (sb.size() < DEPTH);
    pop_ok  = rdy && (sb.size() > 0);
    @(posedge clk);
    #1;
    if (!rst_n || fl) begin
      sb.delete();
    end else begin
      if (pop_ok) void'(sb.pop_front());
      if (push_ok) begin
        e.pc = pc; e.instr = ins;
        sb.push_back(e);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 64'h40, 32'h00148493, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b count=%0d in_ready=%b, want 0/0/0", out_valid, count, in_ready);
    end
    n_cmp++;
    if (out_pc !== '0 || out_instr !== '0 || out_imm !== '0 || out_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data: pc=%h instr=%h imm=%h ill=%b, want zeros", out_pc, out_instr, out_imm, out_illegal);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_decode();
    drive(1'b1, 64'h8, 32'h00148493, 1'b0, 1'b0);
    n_cmp++;
    if (sb.size() == 0 || out_valid !== 1'b1 || out_pc !== sb[0].pc || out_instr !== sb[0].instr) begin
      n_bad++;
      $display("FAIL addi_head: valid=%b pc=%h instr=%h, want 1/8/00148493", out_valid, out_pc, out_instr);
    end
    n_cmp++;
    if (out_opcode !== 7'h13 || out_rd !== 5'd9 || out_rs1 !== 5'd9 || out_funct3 !== 3'd0
        || out_imm !== 64'd1 || out_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_fields: op=%h rd=%0d rs1=%0d f3=%0d imm=%h ill=%b, want 13/9/9/0/1/0",
               out_opcode, out_rd, out_rs1, out_funct3, out_imm, out_illegal);
    end
    drive(1'b1, 64'h10, 32'h0E953823, 1'b1, 1'b0);
    n_cmp++;
    if (sb.size() == 0 || out_pc !== sb[0].pc || count !== 1) begin
      n_bad++;
      $display("FAIL sd_head: pc=%h count=%0d, want 10/1", out_pc, count);
    end
    n_cmp++;
    if (out_opcode !== 7'h23 || out_rs1 !== 5'd10 || out_rs2 !== 5'd9 || out_funct3 !== 3'd3
        || out_imm !== 64'd240 || out_funct7 !== 7'd7) begin
      n_bad++;
      $display("FAIL sd_fields: op=%h rs1=%0d rs2=%0d f3=%0d imm=%h f7=%0d, want 23/10/9/3/f0/7",
               out_opcode, out_rs1, out_rs2, out_funct3, out_imm, out_funct7);
    end
    drive(1'b1, 64'h18, 32'hFE0008E3, 1'b1, 1'b0);
    n_cmp++;
    if (out_opcode !== 7'h63 || out_imm !== 64'hFFFFFFFFFFFFFFF0 || out_pc !== 64'h18) begin
      n_bad++;
      $display("FAIL beq_fields: op=%h imm=%h pc=%h, want 63/fffffffffffffff0/18", out_opcode, out_imm, out_pc);
    end
    drive(1'b1, 64'h1C, 32'h123450B7, 1'b1, 1'b0);
    n_cmp++;
    if (out_imm !== 64'h0000000012345000 || out_rd !== 5'd1 || out_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL lui_fields: imm=%h rd=%0d ill=%b, want 12345000/1/0", out_imm, out_rd, out_illegal);
    end
    drive(1'b1, 64'h20, 32'h0080006F, 1'b1, 1'b0);
    n_cmp++;
    if (out_imm !== 64'd8 || out_opcode !== 7'h6F) begin
      n_bad++;
      $display("FAIL jal_fields: imm=%h op=%h, want 8/6f", out_imm, out_opcode);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 0 || out_opcode !== '0 || out_imm !== '0) begin
      n_bad++;
      $display("FAIL drained: valid=%b count=%0d op=%h imm=%h, want 0/0/0/0", out_valid, count, out_opcode, out_imm);
    end
  endtask

  task automatic test_full_wrap();
    drive(1'b1, 64'h0, 32'h00100093, 1'b0, 1'b0);
    drive(1'b1, 64'h4, 32'h00200113, 1'b0, 1'b0);
    n_cmp++;
    if (count !== DEPTH || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL full_state: count=%0d in_ready=%b valid=%b, want 2/0/1", count, in_ready, out_valid);
    end
    drive(1'b1, 64'h8, 32'h00300193, 1'b0, 1'b0);
    n_cmp++;
    if (count !== DEPTH || sb.size() == 0 || out_pc !== sb[0].pc) begin
      n_bad++;
      $display("FAIL full_ignore: count=%0d pc=%h, want 2/0", count, out_pc);
    end
    // Full with a pop: the push must still be refused this cycle.
    drive(1'b1, 64'hC, 32'h00400213, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 1 || sb.size() != 1 || out_pc !== sb[0].pc || out_pc !== 64'h4) begin
      n_bad++;
      $display("FAIL full_no_passthru: count=%0d pc=%h, want 1/4", count, out_pc);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 64'h100, 32'h00500293, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h104 + 64'(4 * i), 32'h00000013 + 32'(i << 20), 1'b1, 1'b0);
      n_cmp++;
      if (sb.size() == 0 || count !== 1 || out_pc !== sb[0].pc || out_instr !== sb[0].instr) begin
        n_bad++;
        $display("FAIL wrap_order[%0d]: pc=%h instr=%h count=%0d", i, out_pc, out_instr, count);
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 0) begin
      n_bad++;
      $display("FAIL wrap_drain: valid=%b count=%0d, want 0/0", out_valid, count);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_pop: valid=%b count=%0d ready=%b, want 0/0/1", out_valid, count, in_ready);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 64'h200, 32'h00100093, 1'b0, 1'b0);
    drive(1'b1, 64'h204, 32'h00200113, 1'b0, 1'b0);
    drive(1'b1, 64'h208, 32'h00300193, 1'b1, 1'b1);
    n_cmp++;
    if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_state: count=%0d valid=%b ready=%b, want 0/0/1", count, out_valid, in_ready);
    end
    drive(1'b1, 64'h300, 32'h00A00513, 1'b0, 1'b0);
    n_cmp++;
    if (sb.size() == 0 || count !== 1 || out_pc !== sb[0].pc || out_pc !== 64'h300) begin
      n_bad++;
      $display("FAIL flush_next_push: count=%0d pc=%h, want 1/300", count, out_pc);
    end
    drive(1'b1, 64'h304, 32'h00B00593, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (sb.size() == 0 || out_pc !== sb[0].pc || out_pc !== 64'h304) begin
      n_bad++;
      $display("FAIL post_flush_order: pc=%h, want 304", out_pc);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_illegal_reset();
    drive(1'b1, 64'h400, 32'h00000000, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_imm !== '0) begin
      n_bad++;
      $display("FAIL illegal_zero: valid=%b ill=%b imm=%h, want 1/1/0", out_valid, out_illegal, out_imm);
    end
    drive(1'b1, 64'h404, 32'h00B50533, 1'b1, 1'b0);
    n_cmp++;
    if (out_illegal !== 1'b0 || out_imm !== '0 || out_rs2 !== 5'd11 || out_pc !== 64'h404) begin
      n_bad++;
      $display("FAIL rtype: ill=%b imm=%h rs2=%0d pc=%h, want 0/0/11/404", out_illegal, out_imm, out_rs2, out_pc);
    end
    drive(1'b1, 64'h408, 32'h00148492, 1'b1, 1'b0);
    n_cmp++;
    if (out_illegal !== 1'b1 || out_imm !== '0) begin
      n_bad++;
      $display("FAIL compressed_bits: ill=%b imm=%h, want 1/0", out_illegal, out_imm);
    end
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL mid_reset: count=%0d valid=%b ready=%b, want 0/0/0", count, out_valid, in_ready);
    end
    rst_n = 1'b1;
    drive(1'b1, 64'h500, 32'h00148493, 1'b0, 1'b0);
    n_cmp++;
    if (sb.size() == 0 || out_pc !== sb[0].pc || count !== 1) begin
      n_bad++;
      $display("FAIL after_reset_push: pc=%h count=%0d, want 500/1", out_pc, count);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_full_wrap();
    test_flush();
    test_illegal_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
